// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state encoding and transfer direction codes.
// Imported by apb_master.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_t;

  localparam logic APB_WRITE = 1'b1;
  localparam logic APB_READ  = 1'b0;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB master: one command in, one response out.
// Optional ACCESS wait-state timeout when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
  import apb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_write,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_wdata,
  input  logic [DW/8-1:0] i_cmd_strb,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic [AW-1:0]   o_paddr,
  output logic            o_pwrite,
  output logic            o_psel,
  output logic            o_penable,
  output logic [DW-1:0]   o_pwdata,
  output logic [DW/8-1:0] o_pstrb,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pslverr,
  input  logic            i_pready
);

  apb_mst_state_t state;

  assign o_cmd_ready = (state == ST_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= ST_IDLE;
      o_paddr     <= '0;
      o_pwrite    <= 1'b0;
      o_pwdata    <= '0;
      o_pstrb     <= '0;
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            o_paddr  <= i_cmd_addr;
            o_pwrite <= i_cmd_write;
            // Reads put no data or strobes on the bus
            o_pwdata <= (i_cmd_write == APB_WRITE) ? i_cmd_wdata : '0;
            o_pstrb  <= (i_cmd_write == APB_WRITE) ? i_cmd_strb : '0;
            o_psel   <= 1'b1;
            state    <= ST_SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_SETUP: begin
          o_penable <= 1'b1;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (i_pready) begin
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= i_pslverr;
            o_rsp_rdata <= (o_pwrite == APB_READ) ? i_prdata : '0;
            state       <= ST_RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= '0;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
